// File: rtl/corerfd_evtcap.sv
// corerfd_evtcap: counts rising edges of async evt_in per win_end window; ports clk/rst/en/win_end/evt_in/result_ack in, result/result_sat/result_valid/overrun/armed out
module corerfd_evtcap #(
  parameter int CTR_SIZE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                win_end,
  input  logic                evt_in,
  input  logic                result_ack,
  output logic [CTR_SIZE-1:0] result,
  output logic                result_sat,
  output logic                result_valid,
  output logic                overrun,
  output logic                armed
);
  typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;
  state_t state;
  logic s1, s2, s3, evt_p, cnt_sat, at_max, cap;
  logic [CTR_SIZE-1:0] cnt, cnt_inc;
  assign at_max = &cnt;
  assign cnt_inc = at_max ? cnt : cnt + CTR_SIZE'(1);
  assign cap = en && state == COUNT && win_end;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, s3, evt_p} <= '0;
    else {s1, s2, s3, evt_p} <= {evt_in, s1, s2, s2 & ~s3};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
      cnt <= '0;
      cnt_sat <= 1'b0;
      result <= '0;
      result_sat <= 1'b0;
      result_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (!en) begin
        state <= IDLE;
        armed <= 1'b0;
        cnt <= '0;
        cnt_sat <= 1'b0;
      end else if (state == IDLE) state <= ARM;
      else if (state == ARM) begin
        if (win_end) begin
          state <= COUNT;
          armed <= 1'b1;
        end
      end else if (win_end) begin
        cnt <= '0;
        cnt_sat <= 1'b0;
      end else if (evt_p) begin
        cnt <= cnt_inc;
        cnt_sat <= cnt_sat | at_max;
      end
      // an edge landing on the win_end cycle belongs to the ending window
      if (cap) begin
        result <= evt_p ? cnt_inc : cnt;
        result_sat <= cnt_sat | (evt_p & at_max);
        result_valid <= 1'b1;
        overrun <= result_valid & ~result_ack;
      end else if (result_valid && result_ack) begin
        result_valid <= 1'b0;
        overrun <= 1'b0;
      end
    end
endmodule
